fir_xifu_mem_arb: RTL and testbench
===================================

# fir_xifu_mem_arb

Shares the single CV-XIF memory request/result channel of the FIR XIFU between two requesters: port 0 (EX stage load/store of FIR instructions) and port 1 (coefficient/sample stream prefetcher). It arbitrates requests and holds each granted request stable until the core accepts it. It tracks outstanding transactions in an in-order tag FIFO and routes each memory result back to the requester that issued it. It sits between the EX/prefetch units and the `xif_mem`/`xif_mem_result` channels in `fir_xifu_top`.

## Interface
- `MAX_OUTSTANDING`, 2: tag FIFO depth, i.e. the number of accepted requests still awaiting a result (≥1).
- `ID_WIDTH`, 4: XIF instruction id width.
- `clk_i` in 1: clock.
- `clear_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in 2: request valid, one bit per port.
- `req_ready_o` out 2: request accepted, one bit per port.
- `req_addr_i` in 2x32: byte address.
- `req_we_i` in 2: write enable.
- `req_be_i` in 2x4: byte enables.
- `req_wdata_i` in 2x32: write data.
- `req_id_i` in 2xID_WIDTH: XIF id.
- `mem_valid_o` out 1: request to core.
- `mem_ready_i` in 1: core accepts request.
- `mem_addr_o` out 32, `mem_we_o` out 1, `mem_be_o` out 4, `mem_wdata_o` out 32, `mem_id_o` out ID_WIDTH: request payload.
- `mem_result_valid_i` in 1: result from core.
- `mem_result_rdata_i` in 32: read data.
- `mem_result_err_i` in 1: bus error.
- `rsp_valid_o` out 2: result valid, one-hot per port.
- `rsp_rdata_o` out 32: read data, shared.
- `rsp_err_o` out 1: error, shared.
- `proto_err_o` out 1: sticky flag for a result received with no outstanding request.

## Operation
- States: IDLE (no locked request) and LOCKED (a granted request is presented and waiting for `mem_ready_i`).
- IDLE: if any `req_valid_i` is set and the FIFO is not full, grant one port. `mem_valid_o`=1 with that port's payload in the same cycle.
  - If `mem_ready_i`=1: handshake completes, `req_ready_o[g]`=1, tag pushed, stay in IDLE.
  - Otherwise: go to LOCKED and register the grant index.
- LOCKED: the mux stays on the registered index. The other port's valid is ignored. Requesters must hold valid and payload stable.
  - On `mem_ready_i`=1: `req_ready_o[g]`=1, push tag, go to IDLE.
- FIFO full (count == MAX_OUTSTANDING): no new grant, `mem_valid_o`=0. A LOCKED request was already counted when granted, so full never deasserts `mem_valid_o` once it is raised.
- Tag push happens at grant, not at handshake, so a LOCKED request reserves its slot. A push and a pop in the same cycle leave count unchanged. Full is evaluated on the registered count; a same-cycle pop does not admit a new grant.
- Result routing: on `mem_result_valid_i` with FIFO non-empty:
  - `rsp_valid_o[head]`=1, other bit 0.
  - `rsp_rdata_o`/`rsp_err_o` pass through from the core.
  - Pop the FIFO.
- Results arrive in request order (XIF rule); no id matching.
- `mem_result_valid_i` with FIFO empty: drop it, `rsp_valid_o`=0, set `proto_err_o` until `clear_i`.
- FIFO read/write pointers wrap modulo MAX_OUTSTANDING. The count is sized for MAX_OUTSTANDING inclusive.
- `clear_i` mid-transaction: the state machine goes to IDLE, the FIFO empties, and `proto_err_o` clears. Results still in flight afterwards are treated as protocol errors. Issuers must drain or kill before clearing.

## Timing
- Reset values: `mem_valid_o`=0, `req_ready_o`=0, `rsp_valid_o`=0, `proto_err_o`=0. Payload outputs are 0 when `mem_valid_o`=0.
- Request path is combinational: `req_valid_i` to `mem_valid_o` has 0-cycle latency. `mem_ready_i` to `req_ready_o` is combinational. `mem_valid_o` does not depend on `mem_ready_i`.
- Response path is combinational from `mem_result_valid_i` and the FIFO head; 0-cycle latency.
- Registered state: grant state and index, round-robin pointer, FIFO storage, pointers and count, sticky error.

## Configuration
- `FIR_XIFU_MEM_ARB_RR_EN` defined: round-robin arbitration. The port that lost the last completed handshake has priority; the pointer updates only on a handshake. After reset, port 0 has priority.
- Undefined: fixed priority, port 0 always wins. The round-robin pointer register is not instantiated.

## Structure
- Shared package `fir_xifu_pkg` holds:
  - `fir_xifu_mem_req_t` struct (addr, we, be, wdata, id).
  - `fir_xifu_mem_rsp_t` struct (rdata, err).
  - `fir_xifu_arb_state_e` enum (IDLE, LOCKED).
  - `FIR_XIFU_NB_MEM_PORTS`=2.
- One sub-module, `fir_xifu_tag_fifo`: the 1-bit-wide, MAX_OUTSTANDING-deep in-order FIFO with push/pop/full/empty.

## Test plan
- Single read: port 0 valid, addr 0x1000, `mem_ready_i`=1 immediately. Expect `mem_valid_o`=1 and `req_ready_o`=2'b01 in the same cycle. Result rdata 0xCAFEBABE two cycles later gives `rsp_valid_o`=2'b01.
- Lock: port 1 granted, `mem_ready_i` held 0 for 3 cycles while port 0 also asserts valid. Expect the port-1 payload stable for all 4 cycles, then `req_ready_o`=2'b10, then port 0 granted the next cycle.
- Full: MAX_OUTSTANDING=2, two accepted requests with no results. Expect a third request to see `mem_valid_o`=0 until a result pops. Expect a grant the cycle after the pop, not the same cycle.
- Interleaved routing: issue order p0, p1, p0. Results return with rdata 1, 2, 3. Expect `rsp_valid_o` = 01, 10, 01 with matching data. A result with err=1 gives `rsp_err_o`=1 on the owning port.
- Arbitration: both ports valid continuously with `mem_ready_i`=1. With RR enabled, expect grants alternating 0,1,0,1. Without it, expect port 0 on every cycle.
- Protocol error and reset: result with an empty FIFO gives `proto_err_o`=1 and `rsp_valid_o`=0. `clear_i` while LOCKED with 1 outstanding returns all outputs to reset values the next cycle.

Source files
------------

// File: rtl/fir_xifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_xifu_pkg
// Brief    : Shared types and constants for the FIR XIFU memory arbiter.
// Revision : 1.0
// ============================================================================
package fir_xifu_pkg;

    localparam int FIR_XIFU_NB_MEM_PORTS = 2;
    localparam int FIR_XIFU_ID_WIDTH     = 4;

    typedef struct packed {
        logic [31:0]                  addr;
        logic                         we;
        logic [3:0]                   be;
        logic [31:0]                  wdata;
        logic [FIR_XIFU_ID_WIDTH-1:0] id;
    } fir_xifu_mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fir_xifu_mem_rsp_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } fir_xifu_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/fir_xifu_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fir_xifu_tag_fifo
// Brief    : In-order 1-bit tag FIFO recording which port owns each
//            outstanding memory transaction.
// Revision : 1.0
// ============================================================================
module fir_xifu_tag_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Caller guarantees no push when full and no pop when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_xifu_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : fir_xifu_mem_arb
// Brief    : Two-port arbiter for the CV-XIF memory channel with in-order
//            result routing. FIR_XIFU_MEM_ARB_RR_EN selects round-robin.
// Revision : 1.0
// ============================================================================
module fir_xifu_mem_arb
    import fir_xifu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ID_WIDTH        = 4
) (
    input  logic                                             clk_i,
    input  logic                                             clear_i,
    input  logic [FIR_XIFU_NB_MEM_PORTS-1:0]                 req_valid_i,
    output logic [FIR_XIFU_NB_MEM_PORTS-1:0]                 req_ready_o,
    input  logic [FIR_XIFU_NB_MEM_PORTS-1:0][31:0]           req_addr_i,
    input  logic [FIR_XIFU_NB_MEM_PORTS-1:0]                 req_we_i,
    input  logic [FIR_XIFU_NB_MEM_PORTS-1:0][3:0]            req_be_i,
    input  logic [FIR_XIFU_NB_MEM_PORTS-1:0][31:0]           req_wdata_i,
    input  logic [FIR_XIFU_NB_MEM_PORTS-1:0][ID_WIDTH-1:0]   req_id_i,
    output logic                                             mem_valid_o,
    input  logic                                             mem_ready_i,
    output logic [31:0]                                      mem_addr_o,
    output logic                                             mem_we_o,
    output logic [3:0]                                       mem_be_o,
    output logic [31:0]                                      mem_wdata_o,
    output logic [ID_WIDTH-1:0]                              mem_id_o,
    input  logic                                             mem_result_valid_i,
    input  logic [31:0]                                      mem_result_rdata_i,
    input  logic                                             mem_result_err_i,
    output logic [FIR_XIFU_NB_MEM_PORTS-1:0]                 rsp_valid_o,
    output logic [31:0]                                      rsp_rdata_o,
    output logic                                             rsp_err_o,
    output logic                                             proto_err_o
);

    fir_xifu_arb_state_e state;
    fir_xifu_mem_req_t   sel_req;
    fir_xifu_mem_rsp_t   rsp;

    logic grant_idx;
    logic pick;
    logic sel_idx;
    logic any_valid;
    logic push;
    logic pop;
    logic handshake;
    logic head;
    logic full;
    logic empty;

    assign any_valid = |req_valid_i;

`ifdef FIR_XIFU_MEM_ARB_RR_EN
    // Points at the port that lost the last handshake; it wins the next tie.
    logic rr_ptr;

    assign pick = req_valid_i[rr_ptr] ? rr_ptr : ~rr_ptr;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            rr_ptr <= 1'b0;
        end else if (handshake) begin
            rr_ptr <= ~sel_idx;
        end
    end
`else
    assign pick = ~req_valid_i[0];
`endif

    // The tag is pushed at grant so a locked request already owns its slot.
    assign sel_idx     = (state == LOCKED) ? grant_idx : pick;
    assign push        = (state == IDLE) && any_valid && !full;
    assign mem_valid_o = (state == LOCKED) || push;
    assign handshake   = mem_valid_o && mem_ready_i;

    always_comb begin
        req_ready_o          = '0;
        req_ready_o[sel_idx] = handshake;
    end

    always_comb begin
        sel_req = '0;
        if (mem_valid_o) begin
            sel_req.addr  = req_addr_i[sel_idx];
            sel_req.we    = req_we_i[sel_idx];
            sel_req.be    = req_be_i[sel_idx];
            sel_req.wdata = req_wdata_i[sel_idx];
            sel_req.id    = FIR_XIFU_ID_WIDTH'(req_id_i[sel_idx]);
        end
    end

    assign mem_addr_o  = sel_req.addr;
    assign mem_we_o    = sel_req.we;
    assign mem_be_o    = sel_req.be;
    assign mem_wdata_o = sel_req.wdata;
    assign mem_id_o    = ID_WIDTH'(sel_req.id);

    assign pop = mem_result_valid_i && !empty;
    assign rsp = '{rdata: mem_result_rdata_i, err: mem_result_err_i};

    always_comb begin
        rsp_valid_o       = '0;
        rsp_valid_o[head] = pop;
    end

    assign rsp_rdata_o = rsp.rdata;
    assign rsp_err_o   = rsp.err;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state       <= IDLE;
            grant_idx   <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push && !mem_ready_i) begin
                        state     <= LOCKED;
                        grant_idx <= pick;
                    end
                end
                LOCKED: begin
                    if (mem_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (mem_result_valid_i && empty) begin
                proto_err_o <= 1'b1;
            end
        end
    end

    fir_xifu_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk_i),
        .rst   (clear_i),
        .push  (push),
        .din   (pick),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_fir_xifu_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_xifu_mem_arb
// Brief    : Self-checking bench for fir_xifu_mem_arb with a response
//            scoreboard of expected owner port, read data and error.
// Revision : 1.0
// ============================================================================
module tb_fir_xifu_mem_arb;

    logic             clk = 1'b0;
    logic             clear;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_addr;
    logic [1:0]       req_we;
    logic [1:0][3:0]  req_be;
    logic [1:0][31:0] req_wdata;
    logic [1:0][3:0]  req_id;
    logic             mem_valid;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_id;
    logic             res_valid;
    logic [31:0]      res_rdata;
    logic             res_err;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             proto_err;

    int total = 0;
    int bad   = 0;

    int          sb_port[$];
    logic [31:0] sb_data[$];
    logic        sb_err[$];

    always #5 clk = ~clk;

    fir_xifu_mem_arb #(
        .MAX_OUTSTANDING (2),
        .ID_WIDTH        (4)
    ) dut (
        .clk_i              (clk),
        .clear_i            (clear),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_addr_i         (req_addr),
        .req_we_i           (req_we),
        .req_be_i           (req_be),
        .req_wdata_i        (req_wdata),
        .req_id_i           (req_id),
        .mem_valid_o        (mem_valid),
        .mem_ready_i        (mem_ready),
        .mem_addr_o         (mem_addr),
        .mem_we_o           (mem_we),
        .mem_be_o           (mem_be),
        .mem_wdata_o        (mem_wdata),
        .mem_id_o           (mem_id),
        .mem_result_valid_i (res_valid),
        .mem_result_rdata_i (res_rdata),
        .mem_result_err_i   (res_err),
        .rsp_valid_o        (rsp_valid),
        .rsp_rdata_o        (rsp_rdata),
        .rsp_err_o          (rsp_err),
        .proto_err_o        (proto_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        mem_ready = 1'b0;
        res_valid = 1'b0;
        res_rdata = '0;
        res_err   = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input logic [3:0] id);
        req_addr[p]  = a;
        req_we[p]    = we;
        req_be[p]    = 4'hF;
        req_wdata[p] = wd;
        req_id[p]    = id;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Single-cycle accepted request; the expected result is queued now.
    task automatic issue(input int p, input logic [31:0] a, input logic [31:0] rd, input logic er);
        logic [1:0] exp_rdy;
        exp_rdy    = 2'b00;
        exp_rdy[p] = 1'b1;
        set_req(p, a, 1'b0, 32'h0, 4'(p + 1));
        req_valid = exp_rdy;
        mem_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== exp_rdy || mem_addr !== a) begin
            bad++;
            $display("FAIL issue: req_ready=%b addr=%h required req_ready=%b addr=%h",
                     req_ready, mem_addr, exp_rdy, a);
        end
        sb_port.push_back(p);
        sb_data.push_back(rd);
        sb_err.push_back(er);
        tick();
        req_valid = '0;
        mem_ready = 1'b0;
    endtask

    task automatic deliver();
        int          p;
        logic [31:0] d;
        logic        e;
        logic [1:0]  exp_v;
        total++;
        if (sb_port.size() == 0) begin
            bad++;
            $display("FAIL deliver: scoreboard empty, got no entry required one");
            return;
        end
        p        = sb_port.pop_front();
        d        = sb_data.pop_front();
        e        = sb_err.pop_front();
        exp_v    = 2'b00;
        exp_v[p] = 1'b1;
        res_valid = 1'b1;
        res_rdata = d;
        res_err   = e;
        #1;
        if (rsp_valid !== exp_v || rsp_rdata !== d || rsp_err !== e) begin
            bad++;
            $display("FAIL deliver: rsp_valid=%b rdata=%h err=%b required %b %h %b",
                     rsp_valid, rsp_rdata, rsp_err, exp_v, d, e);
        end
        tick();
        res_valid = 1'b0;
        res_rdata = '0;
        res_err   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        for (int p = 0; p < 2; p++) set_req(p, 32'h0, 1'b0, 32'h0, 4'h0);
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        #1;
        total++;
        if (mem_valid !== 1'b0 || req_ready !== 2'b00) begin
            bad++;
            $display("FAIL reset_req: mem_valid=%b req_ready=%b required 0 00", mem_valid, req_ready);
        end
        total++;
        if (rsp_valid !== 2'b00 || proto_err !== 1'b0 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_rsp: rsp_valid=%b proto_err=%b addr=%h required 00 0 0",
                     rsp_valid, proto_err, mem_addr);
        end
        tick();
    endtask

    task automatic test_single_read();
        set_req(0, 32'h0000_1000, 1'b0, 32'h0, 4'h3);
        req_valid = 2'b01;
        mem_ready = 1'b1;
        #1;
        total++;
        if (mem_valid !== 1'b1 || req_ready !== 2'b01 || mem_addr !== 32'h1000 ||
            mem_id !== 4'h3 || mem_be !== 4'hF) begin
            bad++;
            $display("FAIL single_req: mem_valid=%b req_ready=%b addr=%h id=%h be=%h required 1 01 1000 3 f",
                     mem_valid, req_ready, mem_addr, mem_id, mem_be);
        end
        sb_port.push_back(0);
        sb_data.push_back(32'hCAFE_BABE);
        sb_err.push_back(1'b0);
        tick();
        idle_inputs();
        tick();
        deliver();
    endtask

    task automatic test_lock();
        set_req(1, 32'h0000_2000, 1'b1, 32'h0000_55AA, 4'h5);
        set_req(0, 32'h0000_3000, 1'b0, 32'h0, 4'h6);
        req_valid = 2'b10;
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_ready = 1'b1;
            #1;
            total++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 1'b1 ||
                mem_wdata !== 32'h55AA || mem_id !== 4'h5 ||
                req_ready !== ((c == 3) ? 2'b10 : 2'b00)) begin
                bad++;
                $display("FAIL lock_hold[%0d]: valid=%b addr=%h we=%b wdata=%h id=%h rdy=%b required 1 2000 1 55aa 5 %b",
                         c, mem_valid, mem_addr, mem_we, mem_wdata, mem_id, req_ready,
                         (c == 3) ? 2'b10 : 2'b00);
            end
            tick();
            if (c == 0) req_valid = 2'b11;
        end
        sb_port.push_back(1);
        sb_data.push_back(32'h0000_0011);
        sb_err.push_back(1'b0);
        req_valid = 2'b01;
        mem_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01 || mem_addr !== 32'h3000) begin
            bad++;
            $display("FAIL lock_next: req_ready=%b addr=%h required 01 3000", req_ready, mem_addr);
        end
        sb_port.push_back(0);
        sb_data.push_back(32'h0000_0022);
        sb_err.push_back(1'b0);
        tick();
        idle_inputs();
        deliver();
        deliver();
    endtask

    task automatic test_full();
        issue(0, 32'h100, 32'hF000_0001, 1'b0);
        issue(0, 32'h104, 32'hF000_0002, 1'b0);
        set_req(0, 32'h108, 1'b0, 32'h0, 4'h1);
        req_valid = 2'b01;
        mem_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (mem_valid !== 1'b0 || req_ready !== 2'b00) begin
                bad++;
                $display("FAIL full_block[%0d]: mem_valid=%b req_ready=%b required 0 00", c, mem_valid, req_ready);
            end
            tick();
        end
        // Pop in this cycle must not admit the waiting request yet.
        res_valid = 1'b1;
        res_rdata = sb_data.pop_front();
        res_err   = sb_err.pop_front();
        void'(sb_port.pop_front());
        #1;
        total++;
        if (mem_valid !== 1'b0 || rsp_valid !== 2'b01 || rsp_rdata !== 32'hF000_0001) begin
            bad++;
            $display("FAIL full_pop: mem_valid=%b rsp_valid=%b rdata=%h required 0 01 f0000001",
                     mem_valid, rsp_valid, rsp_rdata);
        end
        tick();
        res_valid = 1'b0;
        #1;
        total++;
        if (mem_valid !== 1'b1 || req_ready !== 2'b01 || mem_addr !== 32'h108) begin
            bad++;
            $display("FAIL full_regrant: mem_valid=%b req_ready=%b addr=%h required 1 01 108",
                     mem_valid, req_ready, mem_addr);
        end
        sb_port.push_back(0);
        sb_data.push_back(32'hF000_0003);
        sb_err.push_back(1'b0);
        tick();
        idle_inputs();
        deliver();
        deliver();
    endtask

    task automatic test_interleave();
        issue(0, 32'h200, 32'h1, 1'b0);
        issue(1, 32'h204, 32'h2, 1'b0);
        deliver();
        issue(0, 32'h208, 32'h3, 1'b0);
        deliver();
        deliver();
        issue(1, 32'h20C, 32'hDEAD_BEEF, 1'b1);
        deliver();
    endtask

    task automatic test_back_to_back();
        int          exp_g;
        int          rp;
        logic [31:0] rd;
        logic [1:0]  exp_r;
        do_clear();
        set_req(0, 32'hA00, 1'b0, 32'h0, 4'h1);
        set_req(1, 32'hB00, 1'b0, 32'h0, 4'h2);
        for (int i = 0; i < 4; i++) begin
`ifdef FIR_XIFU_MEM_ARB_RR_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            req_valid = 2'b11;
            mem_ready = 1'b1;
            rp = 0;
            rd = '0;
            if (i > 0) begin
                rp = sb_port.pop_front();
                rd = sb_data.pop_front();
                void'(sb_err.pop_front());
                res_valid = 1'b1;
                res_rdata = rd;
            end
            #1;
            exp_r        = 2'b00;
            exp_r[exp_g] = 1'b1;
            total++;
            if (req_ready !== exp_r || mem_addr !== ((exp_g == 0) ? 32'hA00 : 32'hB00)) begin
                bad++;
                $display("FAIL arb_grant[%0d]: req_ready=%b addr=%h required %b", i, req_ready, mem_addr, exp_r);
            end
            if (i > 0) begin
                exp_r     = 2'b00;
                exp_r[rp] = 1'b1;
                total++;
                if (rsp_valid !== exp_r || rsp_rdata !== rd) begin
                    bad++;
                    $display("FAIL arb_route[%0d]: rsp_valid=%b rdata=%h required %b %h",
                             i, rsp_valid, rsp_rdata, exp_r, rd);
                end
            end
            sb_port.push_back(exp_g);
            sb_data.push_back(32'h100 + 32'(i));
            sb_err.push_back(1'b0);
            tick();
        end
        idle_inputs();
        deliver();
    endtask

    task automatic test_proto_clear();
        do_clear();
        res_valid = 1'b1;
        res_rdata = 32'h1234;
        #1;
        total++;
        if (rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL proto_drop: rsp_valid=%b required 00", rsp_valid);
        end
        tick();
        res_valid = 1'b0;
        #1;
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL proto_set: proto_err=%b required 1", proto_err);
        end
        set_req(0, 32'h500, 1'b0, 32'h0, 4'h1);
        req_valid = 2'b01;
        mem_ready = 1'b0;
        tick();
        #1;
        total++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h500 || req_ready !== 2'b00) begin
            bad++;
            $display("FAIL locked_before_clear: mem_valid=%b addr=%h rdy=%b required 1 500 00",
                     mem_valid, mem_addr, req_ready);
        end
        clear     = 1'b1;
        req_valid = 2'b00;
        tick();
        clear = 1'b0;
        #1;
        total++;
        if (mem_valid !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00 ||
            proto_err !== 1'b0 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL clear_outputs: valid=%b rdy=%b rsp=%b perr=%b addr=%h required 0 00 00 0 0",
                     mem_valid, req_ready, rsp_valid, proto_err, mem_addr);
        end
        // The request dropped by clear must no longer own a FIFO slot.
        res_valid = 1'b1;
        #1;
        total++;
        if (rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL clear_fifo: rsp_valid=%b required 00", rsp_valid);
        end
        tick();
        res_valid = 1'b0;
        #1;
        total++;
        if (proto_err !== 1'b1) begin
            bad++;
            $display("FAIL clear_late_result: proto_err=%b required 1", proto_err);
        end
        do_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_lock();
        test_full();
        test_interleave();
        test_back_to_back();
        test_proto_clear();
        total++;
        if (sb_port.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: entries=%0d required 0", sb_port.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
